// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI byte sequencer.
package spi_seq_pkg;

    localparam int unsigned DEFAULT_FIFO_DEPTH = 8;
    localparam int unsigned DEFAULT_LEN_W      = 8;
    localparam logic [7:0]  DUMMY_BYTE         = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLoad,
        StXfer,
        StHold
    } seq_state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with show-ahead head and wrap-bit pointers.
module sync_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Command/buffer stage in front of the SPI byte master: N-byte transfers under one CS window.
// Define SPI_SEQ_DUMMY_FILL_EN to send DUMMY_BYTE instead of stalling when TX runs dry.
module spi_byte_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned LEN_W      = DEFAULT_LEN_W,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_keep_cs,
    input  logic             tx_wr_en,
    input  logic [7:0]       tx_wr_data,
    output logic             tx_full,
    input  logic             rx_rd_en,
    output logic [7:0]       rx_rd_data,
    output logic             rx_empty,
    output logic             busy,
    output logic             done,
    output logic             spi_cs_n,
    output logic             spi_start,
    output logic [7:0]       spi_tx_data,
    input  logic [7:0]       spi_rx_data,
    input  logic             spi_completed
);

    localparam int unsigned CNT_W      = 8;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             keep_cs_q, keep_cs_d;
    logic             cs_q, cs_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             start_q, start_d;
    logic             done_q, done_d;

    logic       tx_pop, tx_empty, rx_push, rx_full;
    logic [7:0] tx_head;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_wr_en),
        .push_data (tx_wr_data),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (spi_rx_data),
        .pop       (rx_rd_en),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        keep_cs_d   = keep_cs_q;
        cs_d        = cs_q;
        tx_data_d   = tx_data_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = cmd_len;
                        keep_cs_d   = cmd_keep_cs;
                        cnt_d       = '0;
                        // CS still held from a keep_cs command: no setup delay needed.
                        if (cs_q) begin
                            state_d = StLoad;
                        end else begin
                            cs_d    = 1'b1;
                            state_d = StSetup;
                        end
                    end
                end
            end
            StSetup: begin
                if (cnt_q == SETUP_LAST) state_d = StLoad;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            StLoad: begin
`ifdef SPI_SEQ_DUMMY_FILL_EN
                if (!rx_full) begin
                    tx_pop    = !tx_empty;
                    tx_data_d = tx_empty ? DUMMY_BYTE : tx_head;
                    start_d   = 1'b1;
                    state_d   = StXfer;
                end
`else
                if (!tx_empty && !rx_full) begin
                    tx_pop    = 1'b1;
                    tx_data_d = tx_head;
                    start_d   = 1'b1;
                    state_d   = StXfer;
                end
`endif
            end
            StXfer: begin
                if (spi_completed) begin
                    rx_push     = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StHold: begin
                if (keep_cs_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == HOLD_LAST) begin
                    cs_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            cnt_q       <= '0;
            keep_cs_q   <= 1'b0;
            cs_q        <= 1'b0;
            tx_data_q   <= 8'h00;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            keep_cs_q   <= keep_cs_d;
            cs_q        <= cs_d;
            tx_data_q   <= tx_data_d;
            start_q     <= start_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign spi_cs_n    = ~cs_q;
    assign spi_start   = start_q;
    assign spi_tx_data = tx_data_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a 32-cycle SPI master model returning ~tx.
module tb_spi_byte_sequencer;

    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_len = 8'd0;
    logic       cmd_keep_cs = 1'b0;
    logic       tx_wr_en = 1'b0;
    logic [7:0] tx_wr_data = 8'd0;
    logic       tx_full;
    logic       rx_rd_en = 1'b0;
    logic [7:0] rx_rd_data;
    logic       rx_empty;
    logic       busy;
    logic       done;
    logic       spi_cs_n;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic [7:0] spi_rx_data;
    logic       spi_completed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_byte_sequencer #(
        .FIFO_DEPTH (8),
        .LEN_W      (8),
        .CS_SETUP   (CS_SETUP),
        .CS_HOLD    (CS_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_keep_cs   (cmd_keep_cs),
        .tx_wr_en      (tx_wr_en),
        .tx_wr_data    (tx_wr_data),
        .tx_full       (tx_full),
        .rx_rd_en      (rx_rd_en),
        .rx_rd_data    (rx_rd_data),
        .rx_empty      (rx_empty),
        .busy          (busy),
        .done          (done),
        .spi_cs_n      (spi_cs_n),
        .spi_start     (spi_start),
        .spi_tx_data   (spi_tx_data),
        .spi_rx_data   (spi_rx_data),
        .spi_completed (spi_completed)
    );

    // Master model: completes 32 clocks after each start, returning the inverted byte.
    logic       m_busy;
    logic [4:0] m_cnt;
    logic [7:0] m_tx;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_cnt <= '0; m_tx <= '0;
            spi_completed <= 1'b0; spi_rx_data <= '0;
        end else begin
            spi_completed <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 5'd31) begin
                    spi_completed <= 1'b1;
                    spi_rx_data   <= ~m_tx;
                    m_busy        <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 5'd1;
                end
            end else if (spi_start) begin
                m_busy <= 1'b1; m_cnt <= '0; m_tx <= spi_tx_data;
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    int         cyc = 0;
    int         start_cnt = 0, done_cnt = 0, cs_fall_cnt = 0, cs_rise_cnt = 0;
    int         cs_fall_cyc = 0, cs_rise_cyc = 0, last_comp_cyc = 0;
    int         start_cyc [256];
    logic [7:0] tx_log [256];
    logic       cs_n_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spi_start) begin
            tx_log[start_cnt % 256]    = spi_tx_data;
            start_cyc[start_cnt % 256] = cyc;
            start_cnt++;
        end
        if (spi_completed) last_comp_cyc = cyc;
        if (done) done_cnt++;
        if (cs_n_prev && !spi_cs_n) begin cs_fall_cnt++; cs_fall_cyc = cyc; end
        if (!cs_n_prev && spi_cs_n) begin cs_rise_cnt++; cs_rise_cyc = cyc; end
        cs_n_prev = spi_cs_n;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk); tx_wr_en = 1'b1; tx_wr_data = b;
        @(negedge clk); tx_wr_en = 1'b0;
    endtask

    task automatic pop_rx(output logic [7:0] b);
        @(negedge clk); b = rx_rd_data; rx_rd_en = 1'b1;
        @(negedge clk); rx_rd_en = 1'b0;
    endtask

    task automatic issue_cmd(input logic [7:0] len, input logic keep, output int at_cyc);
        @(negedge clk); cmd_valid = 1'b1; cmd_len = len; cmd_keep_cs = keep; at_cyc = cyc;
        @(negedge clk); cmd_valid = 1'b0; cmd_len = 8'd0; cmd_keep_cs = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", spi_start); end
        n_checks++; if (spi_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", spi_tx_data); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL rst_tx_full: got %b want 0", tx_full); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_rx_empty: got %b want 1", rx_empty); end
        n_checks++; if (rx_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", rx_rd_data); end
        @(negedge clk); rst = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        int s0, d0, c;
        logic [7:0] b;
        push_tx(8'hA5);
        push_tx(8'h3C);
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(8'd2, 1'b0, c);
        wait_done(d0, 400, "basic");
        tick(4);
        n_checks++; if (start_cnt - s0 != 2) begin n_fail++; $display("FAIL basic_starts: got %0d want 2", start_cnt - s0); end
        n_checks++; if (tx_log[s0 % 256] !== 8'hA5) begin n_fail++; $display("FAIL basic_tx0: got %h want a5", tx_log[s0 % 256]); end
        n_checks++; if (tx_log[(s0 + 1) % 256] !== 8'h3C) begin n_fail++; $display("FAIL basic_tx1: got %h want 3c", tx_log[(s0 + 1) % 256]); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        n_checks++; if (start_cyc[s0 % 256] - cs_fall_cyc < CS_SETUP) begin n_fail++; $display("FAIL basic_cs_setup: got %0d cycles want >= %0d", start_cyc[s0 % 256] - cs_fall_cyc, CS_SETUP); end
        n_checks++; if (cs_rise_cyc - last_comp_cyc < CS_HOLD) begin n_fail++; $display("FAIL basic_cs_hold: got %0d cycles want >= %0d", cs_rise_cyc - last_comp_cyc, CS_HOLD); end
        n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL basic_cs_end: got %b want 1", spi_cs_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        pop_rx(b);
        n_checks++; if (b !== 8'h5A) begin n_fail++; $display("FAIL basic_rx0: got %h want 5a", b); end
        pop_rx(b);
        n_checks++; if (b !== 8'hC3) begin n_fail++; $display("FAIL basic_rx1: got %h want c3", b); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL basic_rx_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_len_zero();
        int s0, f0;
        s0 = start_cnt; f0 = cs_fall_cnt;
        @(negedge clk); cmd_valid = 1'b1; cmd_len = 8'd0; cmd_keep_cs = 1'b0;
        @(negedge clk); cmd_valid = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", done); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_done_pulse: got %b want 0", done); end
        tick(5);
        n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL len0_no_start: got %0d starts want 0", start_cnt - s0); end
        n_checks++; if (cs_fall_cnt != f0 || spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL len0_cs: got cs_n %b falls %0d want 1 and 0", spi_cs_n, cs_fall_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int s0, d0, f0, r0, c;
        logic [7:0] b;
        push_tx(8'h11);
        push_tx(8'h22);
        r0 = cs_rise_cnt; d0 = done_cnt;
        issue_cmd(8'd1, 1'b1, c);
        wait_done(d0, 200, "b2b_first");
        n_checks++; if (spi_cs_n !== 1'b0 || cs_rise_cnt != r0) begin n_fail++; $display("FAIL b2b_cs_kept: got cs_n %b rises %0d want 0 and 0", spi_cs_n, cs_rise_cnt - r0); end
        s0 = start_cnt; f0 = cs_fall_cnt; d0 = done_cnt;
        issue_cmd(8'd1, 1'b0, c);
        wait_done(d0, 200, "b2b_second");
        tick(2);
        // Through SETUP the start could not appear before issue+CS_SETUP+2.
        n_checks++; if (start_cyc[s0 % 256] - c > CS_SETUP + 1) begin n_fail++; $display("FAIL b2b_no_setup: got start %0d cycles after cmd want <= %0d", start_cyc[s0 % 256] - c, CS_SETUP + 1); end
        n_checks++; if (cs_fall_cnt != f0) begin n_fail++; $display("FAIL b2b_no_refall: got %0d falls want 0", cs_fall_cnt - f0); end
        n_checks++; if (spi_cs_n !== 1'b1 || cs_rise_cnt - r0 != 1) begin n_fail++; $display("FAIL b2b_cs_rise: got cs_n %b rises %0d want 1 and 1", spi_cs_n, cs_rise_cnt - r0); end
        pop_rx(b);
        n_checks++; if (b !== 8'hEE) begin n_fail++; $display("FAIL b2b_rx0: got %h want ee", b); end
        pop_rx(b);
        n_checks++; if (b !== 8'hDD) begin n_fail++; $display("FAIL b2b_rx1: got %h want dd", b); end
    endtask

    task automatic test_rx_full();
        int s0, d0, c;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) push_tx(8'h10 + 8'(i));
        n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL rxf_tx_full: got %b want 1", tx_full); end
        push_tx(8'h99);
        d0 = done_cnt;
        issue_cmd(8'd8, 1'b0, c);
        wait_done(d0, 1000, "rxf_fill");
        push_tx(8'h77);
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(8'd1, 1'b0, c);
        tick(60);
        n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL rxf_stall: got %0d starts want 0", start_cnt - s0); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rxf_busy: got %b want 1", busy); end
        pop_rx(b);
        n_checks++; if (b !== 8'hEF) begin n_fail++; $display("FAIL rxf_first: got %h want ef", b); end
        wait_done(d0, 200, "rxf_resume");
        n_checks++; if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL rxf_resume_start: got %0d want 1", start_cnt - s0); end
        n_checks++; if (tx_log[s0 % 256] !== 8'h77) begin n_fail++; $display("FAIL rxf_tx: got %h want 77", tx_log[s0 % 256]); end
        n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL rxf_rx_nonempty: got %b want 0", rx_empty); end
        for (int i = 1; i < 8; i++) begin
            pop_rx(b);
            n_checks++; if (b !== 8'hEF - 8'(i)) begin n_fail++; $display("FAIL rxf_drain%0d: got %h want %h", i, b, 8'hEF - 8'(i)); end
        end
        pop_rx(b);
        n_checks++; if (b !== 8'h88) begin n_fail++; $display("FAIL rxf_last: got %h want 88", b); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rxf_rx_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_tx_starve();
        int s0, d0, c;
        logic [7:0] b;
        logic [7:0] exp_tx [3];
        push_tx(8'hAA);
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(8'd3, 1'b0, c);
`ifdef SPI_SEQ_DUMMY_FILL_EN
        exp_tx[0] = 8'hAA; exp_tx[1] = 8'hFF; exp_tx[2] = 8'hFF;
`else
        exp_tx[0] = 8'hAA; exp_tx[1] = 8'hBB; exp_tx[2] = 8'hCC;
        tick(100);
        n_checks++; if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL starve_stall: got %0d starts want 1", start_cnt - s0); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL starve_busy: got %b want 1", busy); end
        push_tx(8'hBB);
        push_tx(8'hCC);
`endif
        wait_done(d0, 400, "starve");
        n_checks++; if (start_cnt - s0 != 3) begin n_fail++; $display("FAIL starve_starts: got %0d want 3", start_cnt - s0); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (tx_log[(s0 + i) % 256] !== exp_tx[i]) begin n_fail++; $display("FAIL starve_tx%0d: got %h want %h", i, tx_log[(s0 + i) % 256], exp_tx[i]); end
            pop_rx(b);
            n_checks++; if (b !== ~exp_tx[i]) begin n_fail++; $display("FAIL starve_rx%0d: got %h want %h", i, b, ~exp_tx[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int s0, d0, c;
        logic [7:0] b;
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        s0 = start_cnt;
        issue_cmd(8'd4, 1'b0, c);
        for (int i = 0; i < 200 && start_cnt - s0 < 2; i++) @(negedge clk);
        n_checks++; if (start_cnt - s0 < 2) begin n_fail++; $display("FAIL rstmid_timeout: got %0d starts want 2", start_cnt - s0); end
        tick(5);
        n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_before: got %b want 0", rx_empty); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_async: got %b want 1", spi_cs_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (rx_empty !== 1'b1 || rx_rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx: got empty %b data %h want 1 00", rx_empty, rx_rd_data); end
        n_checks++; if (tx_full !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_flags: got tx_full %b ready %b want 0 1", tx_full, cmd_ready); end
        rst = 1'b1;
        tick(2);
        push_tx(8'h5A);
        s0 = start_cnt; d0 = done_cnt;
        issue_cmd(8'd1, 1'b0, c);
        wait_done(d0, 200, "rstmid_fresh");
        n_checks++; if (start_cnt - s0 != 1 || tx_log[s0 % 256] !== 8'h5A) begin n_fail++; $display("FAIL rstmid_fresh_tx: got %0d starts byte %h want 1 5a", start_cnt - s0, tx_log[s0 % 256]); end
        pop_rx(b);
        n_checks++; if (b !== 8'hA5) begin n_fail++; $display("FAIL rstmid_fresh_rx: got %h want a5", b); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_empty: got %b want 1", rx_empty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_back_to_back();
        test_rx_full();
        test_tx_starve();
        test_reset_mid();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_byte_sequencer.md
Name: spi_byte_sequencer

Overview:
- Upstream command/buffer stage for the SPI byte master. Queues TX bytes, runs N-byte transfers under one chip-select window, and collects received bytes into an RX FIFO.
- Drives the master's start/tx_data pair, consumes its rx_data/completed pair, and owns spi_cs_n.
- Sits between the SoC bus peripheral registers and the SPI byte master.

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of two, ≥2.
- LEN_W, 8, width of the transfer length field.
- CS_SETUP, 2, clk cycles between the CS assert and the first start.
- CS_HOLD, 2, clk cycles between the last completed and the CS deassert.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  transfer request.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LEN_W  bytes to transfer; 0 = no-op.
- cmd_keep_cs  in  1  1 = leave CS asserted after the transfer.
- tx_wr_en  in  1  push tx_wr_data into the TX FIFO.
- tx_wr_data  in  8  byte to send.
- tx_full  out  1  TX FIFO full.
- rx_rd_en  in  1  pop the RX FIFO.
- rx_rd_data  out  8  RX FIFO head; show-ahead.
- rx_empty  out  1  RX FIFO empty.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse when a command finishes.
- spi_cs_n  out  1  chip select, active-low.
- spi_start  out  1  one-cycle start to the master.
- spi_tx_data  out  8  byte to the master; stable from start until completed.
- spi_rx_data  in  8  byte from the master; valid when spi_completed=1.
- spi_completed  in  1  one-cycle master done pulse.

Behaviour:
- Reset (rst=0, async): state IDLE; both FIFOs empty.
  - Outputs: spi_cs_n=1, spi_start=0, spi_tx_data=0, done=0, busy=0, cmd_ready=1, tx_full=0, rx_empty=1, rx_rd_data=0.
  - Reset mid-transfer aborts immediately. CS deasserts asynchronously.
- FSM states: IDLE, SETUP, LOAD, XFER, HOLD.
- IDLE:
  - cmd_valid & cmd_len=0: done pulses next cycle; stay IDLE; CS unchanged.
  - cmd_valid & cmd_len≠0: latch the length into remaining, latch keep_cs.
    - If CS is already asserted from a prior keep_cs command, go to LOAD.
    - Otherwise assert CS and go to SETUP.
- SETUP: count CS_SETUP cycles, then go to LOAD.
- LOAD: wait for TX non-empty AND RX not full. Then pop TX, register the byte on spi_tx_data, and pulse spi_start for exactly one cycle. Go to XFER.
- XFER: wait for spi_completed.
  - On completed, push spi_rx_data into RX in the same cycle and decrement remaining.
  - If remaining reaches 0, go to HOLD; otherwise go to LOAD.
  - Byte-to-byte gap is at least 1 clk.
- HOLD:
  - keep_cs=1: skip the count; CS stays low; done pulses; go to IDLE.
  - Otherwise count CS_HOLD cycles, deassert CS, pulse done, go to IDLE.
- FIFO rules:
  - tx_wr_en while full is dropped.
  - rx_rd_en while empty is ignored.
  - Simultaneous push and pop on a full or empty FIFO: both are legal where meaningful. On a full RX, a pop plus a push frees a slot and keeps the count.
  - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. Full = MSBs differ and the rest are equal.
- tx_wr_en is accepted in every state, including mid-transfer.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- A push to RX never overflows, because LOAD checks RX space before starting a byte.

Optional Feature:
- Macro: SPI_SEQ_DUMMY_FILL_EN.
- Defined: in LOAD with TX empty, the block sends 0xFF without popping, for read-only flash/SD transfers.
- Undefined: LOAD stalls until TX is non-empty.

Decomposition:
- Package spi_seq_pkg:
  - state enum (IDLE, SETUP, LOAD, XFER, HOLD)
  - DUMMY_BYTE = 8'hFF
  - default FIFO_DEPTH / LEN_W constants
- Sub-module: sync_byte_fifo (DEPTH param; push/pop/full/empty/head), instantiated twice.

Test Plan:
- Master model answers each start with completed after 32 clk, returning ~tx. Setup: preload A5,3C; cmd_len=2, keep_cs=0.
  - Two start pulses with tx A5 then 3C.
  - rx FIFO holds 5A,C3.
  - CS low ≥CS_SETUP before the first start and ≥CS_HOLD after the last completed.
  - done pulses once.
- cmd_len=0 → done one cycle later; spi_start never pulses; CS stays 1.
- Back-to-back commands: keep_cs=1 (len 1), then keep_cs=0 (len 1) → CS stays low across both; no SETUP on the second; CS rises after the second.
- RX full: fill RX with 8 bytes unread; cmd_len=1 with TX loaded → no start until one rx_rd_en. Then start is issued and rx_empty=0.
- TX starvation: cmd_len=3 with 1 byte preloaded.
  - Without the macro: stall after byte 1; resume when 2 more bytes are written.
  - With the macro: bytes 2 and 3 are sent as FF.
- Assert rst during XFER of byte 2 of 4 → spi_cs_n=1 immediately; FIFOs empty; busy=0; a fresh command then works normally.
